// File: rtl/lu_serial_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lu_serial_scheduler
// Purpose  : Shares one bit-serial logic unit between two requesters. A
//            round-robin arbiter picks one operation at a time. The operation
//            is evaluated LSB first, one bit per cycle, and the WIDTH-bit
//            result is presented on a valid/ready result channel.
// Revision : 1.0 - initial release
// ============================================================================
module lu_serial_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_sel,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_sel,
  // result channel
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             busy
);

  // Counter must address bits 0..WIDTH-1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  // Function select encodings.
  localparam logic [1:0] C_SEL_NOR  = 2'b00;
  localparam logic [1:0] C_SEL_OR   = 2'b01;
  localparam logic [1:0] C_SEL_XOR  = 2'b10;
  localparam logic [1:0] C_SEL_XNOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             rr_q,    rr_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [1:0]       sel_q,   sel_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             id_q,    id_d;

  logic grant0;
  logic grant1;
  logic accept0;
  logic accept1;
  logic a_bit;
  logic b_bit;
  logic lu_bit;

  // A lone valid always wins; on contention the rr pointer decides.
  assign grant0 = req0_valid & (~req1_valid | ~rr_q);
  assign grant1 = req1_valid & (~req0_valid |  rr_q);

  // Readies are only offered in IDLE and are held low during reset, so the
  // upstream side never sees a handshake that the registers will discard.
  assign accept0 = rst_n & (state_q == S_IDLE) & grant0;
  assign accept1 = rst_n & (state_q == S_IDLE) & grant1;

  assign req0_ready = accept0;
  assign req1_ready = accept1;

  // Bit slice presented to the logic unit this cycle.
  assign a_bit = a_q[cnt_q];
  assign b_bit = b_q[cnt_q];

  // One-bit logic unit.
  always_comb begin
    lu_bit = 1'b0;
    case (sel_q)
      C_SEL_NOR:  lu_bit = ~(a_bit | b_bit);
      C_SEL_OR:   lu_bit =   a_bit | b_bit;
      C_SEL_XOR:  lu_bit =   a_bit ^ b_bit;
      C_SEL_XNOR: lu_bit = ~(a_bit ^ b_bit);
      default:    lu_bit = 1'b0;
    endcase
  end

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    id_d    = id_q;

    case (state_q)
      S_IDLE: begin
        if (accept0 || accept1) begin
          // Operands are latched here so later changes upstream cannot
          // disturb the operation in flight.
          a_d     = accept1 ? req1_a   : req0_a;
          b_d     = accept1 ? req1_b   : req0_b;
          sel_d   = accept1 ? req1_sel : req0_sel;
          id_d    = accept1;
          res_d   = '0;
          cnt_d   = '0;
          rr_d    = ~accept1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        res_d[cnt_q] = lu_bit;
        if (cnt_q == C_CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_DONE: begin
        // Result stays on the channel until the consumer takes it.
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 2'b00;
      res_q   <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      id_q    <= id_d;
    end
  end

  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) | (state_q == S_DONE);
  assign res_data  = res_q;
  assign res_id    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_lu_serial_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lu_serial_scheduler
// Purpose  : Directed self-checking bench for lu_serial_scheduler (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lu_serial_scheduler;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [1:0]       req0_sel;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [1:0]       req1_sel;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  lu_serial_scheduler #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .busy       (busy)
  );

  // ---------------------------------------------------------------- helpers
  task automatic apply_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = 2'b00;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = 2'b00;
    res_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  // Polls the selected ready once per cycle (just after each edge).
  task automatic wait_ready(input logic id, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Cycles from the current edge until res_valid is seen; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (res_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    res_ready  = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset_res_data: got %h expected 00", res_data); end
    checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL reset_res_id: got %b expected 0", res_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_readies: got %b expected 00", {req0_ready, req1_ready}); end
    @(posedge clk);
    #1;
    checks++; if ({req0_ready, req1_ready, busy} !== 3'b000) begin errors++; $display("FAIL reset_held_edge: got %b expected 000", {req0_ready, req1_ready, busy}); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    int lat;
    req0_a = 8'hF0; req0_b = 8'hAA; req0_sel = 2'b10; req0_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready}); end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    checks++; if ({busy, req0_ready} !== 2'b10) begin errors++; $display("FAIL single_run_busy: got %b expected 10", {busy, req0_ready}); end
    wait_valid(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL single_latency: got %0d expected 8", lat); end
    checks++; if (res_data !== 8'h5A) begin errors++; $display("FAIL single_data: got %h expected 5a", res_data); end
    checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL single_id: got %b expected 0", res_id); end
    handshake();
    checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL single_after_hs: got %b expected 00", {res_valid, busy}); end
    checks++; if (res_data !== 8'h5A) begin errors++; $display("FAIL single_data_kept: got %h expected 5a", res_data); end
  endtask

  task automatic test_functions();
    logic [7:0] exp_d [4];
    int lat;
    bit ok;
    exp_d[0] = 8'hC0; exp_d[1] = 8'h3F; exp_d[2] = 8'h3C; exp_d[3] = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      req1_a = 8'h0F; req1_b = 8'h33; req1_sel = 2'(i); req1_valid = 1'b1;
      #1;
      wait_ready(1'b1, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL func%0d_ready: got %b expected 1", i, ok); end
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      wait_valid(lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL func%0d_latency: got %0d expected 8", i, lat); end
      checks++; if (res_data !== exp_d[i]) begin errors++; $display("FAIL func%0d_data: got %h expected %h", i, res_data, exp_d[i]); end
      checks++; if (res_id !== 1'b1) begin errors++; $display("FAIL func%0d_id: got %b expected 1", i, res_id); end
      handshake();
    end
  endtask

  task automatic test_contention();
    int lat;
    bit ok;
    logic who;
    apply_reset();
    req0_a = 8'hF0; req0_b = 8'h0F; req0_sel = 2'b10; req0_valid = 1'b1;
    req1_a = 8'h3C; req1_b = 8'hC3; req1_sel = 2'b00; req1_valid = 1'b1;
    #1;
    for (int n = 0; n < 4; n++) begin
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if ((req0_ready | req1_ready) === 1'b1) begin ok = 1'b1; break; end
        @(posedge clk);
        #1;
      end
      who = req1_ready;
      checks++; if (ok !== 1'b1 || (req0_ready & req1_ready) !== 1'b0) begin errors++; $display("FAIL cont%0d_one_ready: got %b%b expected exactly one", n, req0_ready, req1_ready); end
      checks++; if (who !== n[0]) begin errors++; $display("FAIL cont%0d_grant: got %b expected %b", n, who, n[0]); end
      @(posedge clk);
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL cont%0d_run_readies: got %b expected 00", n, {req0_ready, req1_ready}); end
      wait_valid(lat);
      checks++; if (res_id !== n[0]) begin errors++; $display("FAIL cont%0d_id: got %b expected %b", n, res_id, n[0]); end
      checks++; if (res_data !== (n[0] ? 8'h00 : 8'hFF)) begin errors++; $display("FAIL cont%0d_data: got %h expected %h", n, res_data, (n[0] ? 8'h00 : 8'hFF)); end
      handshake();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    bit ok;
    req0_a = 8'h12; req0_b = 8'h34; req0_sel = 2'b10; req0_valid = 1'b1;
    #1;
    wait_ready(1'b0, ok);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_a = 8'h00; req1_b = 8'h00; req1_sel = 2'b11; req1_valid = 1'b1;
    wait_valid(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency: got %0d expected 8", lat); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++; if ({res_valid, res_id, res_data} !== {1'b1, 1'b0, 8'h26}) begin errors++; $display("FAIL bp_hold%0d: got v=%b id=%b d=%h expected v=1 id=0 d=26", k, res_valid, res_id, res_data); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_readies%0d: got %b expected 00", k, {req0_ready, req1_ready}); end
    end
    handshake();
    checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_release: got %b expected 00", {res_valid, busy}); end
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_next_grant: got %b expected 1", req1_ready); end
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    wait_valid(lat);
    checks++; if ({res_id, res_data} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL bp_second: got id=%b d=%h expected id=1 d=ff", res_id, res_data); end
    handshake();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit ok;
    req0_a = 8'hFF; req0_b = 8'h00; req0_sel = 2'b01; req0_valid = 1'b1;
    #1;
    wait_ready(1'b0, ok);
    @(posedge clk);
    #1;
    // rr now points at requester 1; queue both requests behind the reset.
    req0_a = 8'h81; req0_b = 8'h18; req0_sel = 2'b10; req0_valid = 1'b1;
    req1_a = 8'h55; req1_b = 8'h0F; req1_sel = 2'b01; req1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, res_data} !== {1'b1, 8'h07}) begin errors++; $display("FAIL rst_partial: got busy=%b d=%h expected busy=1 d=07", busy, res_data); end
    rst_n = 1'b0;
    #1;
    checks++; if ({res_valid, busy, res_id} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags: got %b expected 000", {res_valid, busy, res_id}); end
    checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", res_data); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL rst_mid_readies: got %b expected 00", {req0_ready, req1_ready}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rst_rr_grant: got %b expected 10", {req0_ready, req1_ready}); end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    wait_valid(lat);
    checks++; if ({res_id, res_data} !== {1'b0, 8'h99}) begin errors++; $display("FAIL rst_first: got id=%b d=%h expected id=0 d=99", res_id, res_data); end
    handshake();
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rst_second_ready: got %b expected 1", req1_ready); end
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    wait_valid(lat);
    checks++; if ({res_id, res_data} !== {1'b1, 8'h5F}) begin errors++; $display("FAIL rst_second: got id=%b d=%h expected id=1 d=5f", res_id, res_data); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    int t1;
    int t2;
    bit ok;
    res_ready = 1'b1;
    req0_a = 8'hF0; req0_b = 8'hAA; req0_sel = 2'b10; req0_valid = 1'b1;
    #1;
    wait_ready(1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b expected 1", ok); end
    @(posedge clk);
    #1;
    t1 = cyc;
    req0_a = 8'h0F; req0_b = 8'h33; req0_sel = 2'b00;
    wait_valid(lat);
    checks++; if ({res_id, res_data} !== {1'b0, 8'h5A}) begin errors++; $display("FAIL b2b_first: got id=%b d=%h expected id=0 d=5a", res_id, res_data); end
    wait_ready(1'b0, ok);
    @(posedge clk);
    #1;
    t2 = cyc;
    req0_valid = 1'b0;
    checks++; if (t2 - t1 !== 10) begin errors++; $display("FAIL b2b_interval: got %0d expected 10", t2 - t1); end
    wait_valid(lat);
    checks++; if ({res_id, res_data} !== {1'b0, 8'hC0}) begin errors++; $display("FAIL b2b_second: got id=%b d=%h expected id=0 d=c0", res_id, res_data); end
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL b2b_idle: got %b expected 00", {res_valid, busy}); end
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_single();
    test_functions();
    test_contention();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/lu_serial_scheduler.md
Name: lu_serial_scheduler

Overview:
- Time-shares one bit-serial logic unit between two requesters. Each requester submits a WIDTH-bit operand pair plus a 2-bit function select.
- A round-robin arbiter grants one request at a time. The FSM then steps the 1-bit LU across the operand bits, one bit per cycle, and presents the WIDTH-bit result on a valid/ready output channel.
- Sits between the operation sources and the result consumer, in place of a parallel logic array.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2); also the number of RUN cycles per operation.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand a.
- req0_b  input  WIDTH  requester 0 operand b.
- req0_sel  input  2  requester 0 function select.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as requester 0, for requester 1.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes the result.
- res_data  output  WIDTH  result word.
- res_id  output  1  index of the requester that owns res_data.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Function select, applied per bit i: 00 NOR ~(a|b), 01 OR a|b, 10 XOR a^b, 11 XNOR ~(a^b).
- Reset (rst_n low, asynchronous): state=IDLE, bit counter=0, rr pointer=0.
- Registered outputs under reset: res_valid=0, res_data=0, res_id=0, busy=0.
- req0_ready and req1_ready are forced to 0 while rst_n is low.
- FSM states: IDLE, RUN, DONE.
- IDLE, arbitration:
  - Only one valid: grant that requester.
  - Both valid: grant the requester equal to rr.
  - Grant is signalled by the combinational reqN_ready=(state==IDLE)&grantN. At most one ready is high at a time.
- IDLE, on an accept edge:
  - Capture a, b, sel; set res_id=granted index; clear the result register to 0.
  - Set counter=0, rr=~granted; go to RUN.
  - No valid: stay in IDLE.
- RUN:
  - Each posedge writes result[cnt]=LU(a[cnt],b[cnt],sel) and increments cnt.
  - The edge with cnt==WIDTH-1 writes the last bit and moves to DONE; the counter returns to 0.
  - RUN therefore lasts exactly WIDTH cycles, processing bits LSB first.
- DONE:
  - res_valid=1; res_data and res_id are held stable.
  - On posedge with res_ready=1, go to IDLE with res_valid=0. res_data keeps its last value until the next accept.
  - While res_ready=0, stay in DONE indefinitely.
- Latency: res_valid rises WIDTH cycles after the accept edge. Minimum issue interval is WIDTH+2 cycles (accept, WIDTH RUN cycles, DONE handshake).
- Both readies are 0 in RUN and DONE; requests are not queued.
- Requester rules: valid must stay high, with a/b/sel stable, until ready. Operand changes after accept have no effect on the operation in flight.
- Simultaneous events:
  - A requester dropping valid in the same cycle as ready: still accepted (sampled at the edge).
  - res_ready high before DONE: ignored.
- Reset mid-RUN or mid-DONE: the operation is discarded, all outputs return to reset values, rr returns to 0, and no result is emitted.
- busy = (state==RUN)|(state==DONE).

Test Plan (WIDTH=8):
- Single op: req0 a=F0 b=AA sel=10 → accepted in 1 cycle; after 8 cycles res_valid=1, res_data=5A, res_id=0.
- All functions on a=0F b=33 via req1: sel 00→C0, 01→3F, 10→3C, 11→C3. Each has res_id=1 and 8-cycle latency.
- Contention: both valid from reset, each held until accepted → req0 served first, then req1. With req0 re-asserted, the grant order continues 0,1,0,1; each result is tagged correctly.
- Backpressure: res_ready low for 5 cycles in DONE → res_valid, res_data and res_id are held; both readies stay 0. Raising res_ready returns the FSM to IDLE next edge.
- Reset mid-RUN: pull rst_n low after 3 RUN cycles → res_valid=0, res_data=0, busy=0, readies 0 immediately. After release, the pending req1 (with req0 also valid) gets req0 served first, since rr=0.
- Single requester back-to-back: req0 valid continuously, res_ready=1 → accepts 10 cycles apart. The second result matches the new operands, even when they were changed right after the first accept.
